hazard_unit_mc: RTL and testbench

- Next-generation hazard unit for the 5-stage RISC-V pipeline. Keeps M-over-W forwarding and load-use and branch control.
- Adds a parametrised register-address width and source-use qualifiers, so no false stalls occur on unused rs fields.
- Adds a sequential FSM that holds a multi-cycle execute op (mul/div) in E for MD_LATENCY cycles while bubbles go into M.
- Sits beside the datapath; all pipeline-register enables and clears come from here.

---
 rtl/hazard_unit_mc.sv | 133 +++++++++++++
 tb/tb_hazard_unit_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use and branch control,
// and a multi-cycle execute hold FSM. Optional perf counters under HAZARD_PERF_EN.
module hazard_unit_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic                  useRs1D,
    input  logic                  useRs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  resultSrcE_0,
    input  logic                  mdE,
    input  logic                  PcSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    output logic [1:0]            forwardAE,
    output logic [1:0]            forwardBE,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  flushM,
    output logic                  mdBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     stallCount,
    output logic [PERF_W-1:0]     flushCount
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    localparam bit       MD_EN    = (MD_LATENCY > 1);
    localparam logic [3:0] CNT_INIT = (MD_LATENCY >= 2) ? 4'(MD_LATENCY - 2) : 4'd0;

    md_state_t  state;
    logic [3:0] cnt;
    logic       lw_stall;
    logic       md_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        if (rs != '0 && we_m && rs == rd_m)      return 2'b10;
        else if (rs != '0 && we_w && rs == rd_w) return 2'b01;
        else                                     return 2'b00;
    endfunction

    always_comb begin
        lw_stall = resultSrcE_0 && (RdE != '0) &&
                   ((useRs1D && Rs1D == RdE) || (useRs2D && Rs2D == RdE));
        md_stall = 1'b0;
        case (state)
            IDLE:    md_stall = mdE && MD_EN;
            BUSY:    md_stall = 1'b1;
            default: md_stall = 1'b0;
        endcase
    end

    // Reset forces a clean pipeline: no stalls, D/E cleared to bubbles.
    always_comb begin
        if (reset) begin
            forwardAE = 2'b00;
            forwardBE = 2'b00;
            stallF    = 1'b0;
            stallD    = 1'b0;
            stallE    = 1'b0;
            flushD    = 1'b1;
            flushE    = 1'b1;
            flushM    = 1'b0;
            mdBusy    = 1'b0;
        end else begin
            forwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            forwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            stallF    = lw_stall | md_stall;
            stallD    = lw_stall | md_stall;
            stallE    = md_stall;
            flushD    = PcSrcE & ~md_stall;
            flushE    = (lw_stall | PcSrcE) & ~md_stall;
            flushM    = md_stall;
            mdBusy    = (state != IDLE);
        end
    end

    // cnt holds the remaining BUSY cycles; DONE is the single advance cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdE && MD_EN) begin
                        cnt   <= CNT_INIT;
                        state <= (MD_LATENCY == 2) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stallF)          stallCount <= stallCount + 1'b1;
            if (flushD | flushE) flushCount <= flushCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: vector table, hand sequences for the
// multi-cycle FSM, and randomized traffic against a cycle-count reference model.
module tb_hazard_unit_mc;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       useRs1D, useRs2D, resultSrcE_0, mdE, PcSrcE, RegWriteM, RegWriteW;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM, mdBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stallCount, flushCount;
`endif

    int pass_cnt = 0;
    int total    = 0;
    int k        = 0;  // cycles the current md op has spent in E (0 = none)

    hazard_unit_mc #(.REG_ADDR_W(5), .MD_LATENCY(L), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .resultSrcE_0(resultSrcE_0),
        .mdE(mdE), .PcSrcE(PcSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .mdBusy(mdBusy)
`ifdef HAZARD_PERF_EN
        , .stallCount(stallCount), .flushCount(flushCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d;
        logic       u1, u2;
        logic [4:0] rs1e, rs2e, rde;
        logic       ld, pc;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
        logic [1:0] fa, fb;
        logic       st, fd, fe;
    } vec_t;

    function automatic logic [10:0] mk(logic [1:0] fa, logic [1:0] fb, logic st, logic se,
                                       logic fd, logic fe, logic fm, logic busy);
        return {fa, fb, st, st, se, fd, fe, fm, busy};
    endfunction

    function automatic logic [10:0] act();
        return {forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM, mdBusy};
    endfunction

    function automatic logic [1:0] ref_fwd(logic [4:0] rs);
        if (rs == 0)                    return 2'b00;
        if (RegWriteM && rs == RdM)     return 2'b10;
        if (RegWriteW && rs == RdW)     return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [10:0] model_out();
        logic lw, md;
        if (reset) return mk(0, 0, 0, 0, 1, 1, 0, 0);
        lw = resultSrcE_0 && RdE != 0 && ((useRs1D && Rs1D == RdE) || (useRs2D && Rs2D == RdE));
        md = (k == 0) ? (mdE && L > 1) : (k < L - 1);
        return mk(ref_fwd(Rs1E), ref_fwd(Rs2E), lw | md, md,
                  PcSrcE & ~md, (lw | PcSrcE) & ~md, md, k != 0);
    endfunction

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        total++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    task automatic model_step();
        if (reset)       k = 0;
        else if (k == 0) begin if (mdE && L > 1) k = 1; end
        else if (k < L - 1) k++;
        else             k = 0;
    endtask

    task automatic tick(string name, logic [10:0] e);
        @(negedge clk);
        chk(name, 32'(act()), 32'(e));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {useRs1D, useRs2D, resultSrcE_0, mdE, PcSrcE, RegWriteM, RegWriteW} = '0;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{0,0,0,0,5,0,0,0,0,5,1,5,1,2'b10,2'b00,0,0,0};
        tbl[1] = '{0,0,0,0,0,0,0,0,0,5,1,5,1,2'b00,2'b00,0,0,0};
        tbl[2] = '{0,0,0,0,5,0,0,0,0,5,0,5,1,2'b01,2'b00,0,0,0};
        tbl[3] = '{0,0,0,0,3,9,0,0,0,9,1,9,1,2'b00,2'b10,0,0,0};
        tbl[4] = '{0,7,0,1,0,0,7,1,0,0,0,0,0,2'b00,2'b00,1,0,1};
        tbl[5] = '{0,7,0,0,0,0,7,1,0,0,0,0,0,2'b00,2'b00,0,0,0};
        tbl[6] = '{0,0,0,1,0,0,0,1,0,0,0,0,0,2'b00,2'b00,0,0,0};
        tbl[7] = '{4,0,1,0,0,0,4,1,0,0,0,0,0,2'b00,2'b00,1,0,1};
        tbl[8] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,2'b00,2'b00,0,1,1};
        tbl[9] = '{0,0,0,0,0,6,0,0,0,6,0,6,1,2'b00,2'b01,0,0,0};

        clr();
        reset = 1'b1;
        tick("reset0", mk(0, 0, 0, 0, 1, 1, 0, 0));
        tick("reset1", mk(0, 0, 0, 0, 1, 1, 0, 0));
        reset = 1'b0;

        foreach (tbl[i]) begin
            Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; useRs1D = tbl[i].u1; useRs2D = tbl[i].u2;
            Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e; RdE = tbl[i].rde;
            resultSrcE_0 = tbl[i].ld; PcSrcE = tbl[i].pc;
            RdM = tbl[i].rdm; RegWriteM = tbl[i].rwm; RdW = tbl[i].rdw; RegWriteW = tbl[i].rww;
            mdE = 1'b0;
            tick($sformatf("vec%0d", i),
                 mk(tbl[i].fa, tbl[i].fb, tbl[i].st, 0, tbl[i].fd, tbl[i].fe, 0, 0));
        end

        // md op held in E: three stalled cycles then the advance cycle
        clr();
        mdE = 1'b1;
        tick("md_c0", mk(0, 0, 1, 1, 0, 0, 1, 0));
        tick("md_c1", mk(0, 0, 1, 1, 0, 0, 1, 1));
        tick("md_c2", mk(0, 0, 1, 1, 0, 0, 1, 1));
        tick("md_c3", mk(0, 0, 0, 0, 0, 0, 0, 1));
        mdE = 1'b0;
        tick("md_idle", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // branch while E is held: flushes masked
        mdE = 1'b1;
        tick("mdbr_c0", mk(0, 0, 1, 1, 0, 0, 1, 0));
        mdE = 1'b0; PcSrcE = 1'b1;
        tick("mdbr_c1", mk(0, 0, 1, 1, 0, 0, 1, 1));
        PcSrcE = 1'b0;
        tick("mdbr_c2", mk(0, 0, 1, 1, 0, 0, 1, 1));
        tick("mdbr_c3", mk(0, 0, 0, 0, 0, 0, 0, 1));

        // reset mid-BUSY aborts; next op restarts the full hold
        mdE = 1'b1;
        tick("rst_c0", mk(0, 0, 1, 1, 0, 0, 1, 0));
        tick("rst_c1", mk(0, 0, 1, 1, 0, 0, 1, 1));
        reset = 1'b1;
        tick("rst_hit", mk(0, 0, 0, 0, 1, 1, 0, 0));
        reset = 1'b0; mdE = 1'b0;
        tick("rst_after", mk(0, 0, 0, 0, 0, 0, 0, 0));
        mdE = 1'b1;
        tick("rst_new0", mk(0, 0, 1, 1, 0, 0, 1, 0));
        mdE = 1'b0;
        tick("rst_new1", mk(0, 0, 1, 1, 0, 0, 1, 1));
        tick("rst_new2", mk(0, 0, 1, 1, 0, 0, 1, 1));
        tick("rst_new3", mk(0, 0, 0, 0, 0, 0, 0, 1));
        tick("rst_new4", mk(0, 0, 0, 0, 0, 0, 0, 0));

        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 59) == 0);
            Rs1D         = 5'($urandom_range(0, 3));
            Rs2D         = 5'($urandom_range(0, 3));
            Rs1E         = 5'($urandom_range(0, 3));
            Rs2E         = 5'($urandom_range(0, 3));
            RdE          = 5'($urandom_range(0, 3));
            RdM          = 5'($urandom_range(0, 3));
            RdW          = 5'($urandom_range(0, 3));
            useRs1D      = 1'($urandom_range(0, 1));
            useRs2D      = 1'($urandom_range(0, 1));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            resultSrcE_0 = ($urandom_range(0, 2) == 0);
            mdE          = ($urandom_range(0, 5) == 0);
            PcSrcE       = ($urandom_range(0, 6) == 0);
            tick("rand", model_out());
        end

`ifdef HAZARD_PERF_EN
        clr();
        reset = 1'b1;
        tick("perf_rst", mk(0, 0, 0, 0, 1, 1, 0, 0));
        reset = 1'b0;
        resultSrcE_0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; useRs2D = 1'b1;
        tick("perf_lw", mk(0, 0, 1, 0, 0, 1, 0, 0));
        clr();
        PcSrcE = 1'b1;
        tick("perf_br", mk(0, 0, 0, 0, 1, 1, 0, 0));
        PcSrcE = 1'b0;
        @(negedge clk);
        chk("stallCount", stallCount, 32'd1);
        chk("flushCount", flushCount, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("stallCount_rst", stallCount, 32'd0);
        chk("flushCount_rst", flushCount, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
